stage3_pipe: RTL and testbench
==============================

Name: stage3_pipe

Overview:
- Stage-2 → stage-3 (EX/MEM) pipeline register plus load-use hazard controller.
- Captures the stage-2 ALU result, opcode, destination and store data each cycle. These become the stage-3 view consumed by the forwarding mux and the data-memory port.
- The forwarding mux only bypasses ALU/LUI/AUIPC results from stage 3. This block therefore stalls stage 2 and inserts bubbles whenever stage 2 reads the destination of a load sitting in stage 3.

Parameters:
- LOAD_LAT, 2, cycles stage 2 is held per load-use hazard; must be ≥1.
- XLEN, 32, datapath width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- ALUOUT_STAGE2  input  XLEN  ALU result computed in stage 2.
- RS2_FWD_STAGE2  input  XLEN  forwarded rs2 value; becomes store data.
- OPCODE_STAGE2  input  7  stage-2 instruction opcode.
- wr_addr_STAGE2  input  5  stage-2 destination register.
- WR_EN_STAGE2  input  1  stage-2 register-write enable.
- RADDR1_STAGE2  input  5  stage-2 rs1 index.
- RADDR2_STAGE2  input  5  stage-2 rs2 index.
- FLUSH  input  1  branch/jump squash of stage 2.
- HOLD_IN  input  1  data memory busy; freeze stage 3.
- ALUOUT_STAGE3  output  XLEN  registered ALU result / memory address.
- STORE_DATA_STAGE3  output  XLEN  registered store data.
- OPCODE_STAGE3  output  7  registered opcode.
- wr_addr_STAGE3  output  5  registered destination.
- WR_EN_STAGE3  output  1  registered write enable.
- VALID_STAGE3  output  1  stage 3 holds a real instruction.
- STALL_STAGE2  output  1  hold PC, stage 1 and stage 2 this cycle.

Behaviour:
- Reset (rst_n low, async): all stage-3 outputs 0, state RUN, counter 0, STALL_STAGE2 0.
- WR_EN captured as WR_EN_STAGE2 & (wr_addr_STAGE2 != 0); x0 never marked written.
- Bubble means VALID=0, WR_EN=0, OPCODE=0, data/address fields 0.
- Hazard (combinational), true when all of the following hold:
  - VALID_STAGE3 and OPCODE_STAGE3 == 7'b0000011 (load);
  - WR_EN_STAGE3;
  - wr_addr_STAGE3 == RADDR1_STAGE2 or wr_addr_STAGE3 == RADDR2_STAGE2.
- States: RUN, WAIT. Counter width $clog2(LOAD_LAT+1).
- Per-edge priority, highest first:
  1. FLUSH: stage 3 ← bubble; state → RUN; counter → 0; STALL_STAGE2 = 0 combinationally, even if a hazard or WAIT is present.
  2. HOLD_IN: stage 3 registers keep their value; state and counter frozen; STALL_STAGE2 = 1.
  3. RUN with hazard:
     - STALL_STAGE2 = 1 (Mealy output);
     - stage 3 ← bubble, so the load leaves stage 3;
     - if LOAD_LAT > 1: counter ← LOAD_LAT−1 and state → WAIT; else stay in RUN.
  4. WAIT:
     - STALL_STAGE2 = 1; stage 3 ← bubble; counter decrements;
     - when counter == 1 at the edge → RUN. The held instruction then enters stage 3 on the next non-stalled edge.
  5. RUN, no hazard: stage 3 ← stage-2 fields; VALID ← 1; STALL_STAGE2 = 0.
- Latency: 1 cycle stage 2 → stage 3 when not stalled. A load-use pair costs exactly LOAD_LAT bubble cycles.
- FLUSH during WAIT aborts the stall in the same cycle: the stalled instruction is squashed upstream.
- HOLD_IN during WAIT extends the stall by the number of cycles HOLD_IN is high.
- Back-to-back loads with a dependency each trigger their own stall; no hazard merging.
- A non-load in stage 3 never stalls; it is handled by forwarding.
- A load to x0 never stalls, because WR_EN is 0.

Decomposition:
- Shared package pipe_pkg:
  - opcode constants OP_LOAD, OP_STORE, OP_ALUI, OP_ALUR, OP_LUI, OP_AUIPC;
  - typedef stage3_t, a struct of alu/store/opcode/wr_addr/wr_en/valid;
  - BUBBLE_S3 constant.
- One sub-module, load_use_detect: the combinational hazard compare, reusable for a later stage-4 check.
- FSM and registers stay in stage3_pipe.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with stage 3 full → all outputs 0 immediately, independent of clk. Release → first captured instruction appears 1 cycle later.
- ALU passthrough: addi x5 (OPCODE 0010011, ALUOUT 0x0000_0010, wr_addr 5, WR_EN 1) → next cycle ALUOUT_STAGE3=0x10, wr_addr_STAGE3=5, VALID=1, STALL=0.
- Load-use, LOAD_LAT=2: lw x7 in stage 3, stage 2 RADDR1=7 → STALL_STAGE2 high exactly 2 cycles, VALID_STAGE3=0 for 2 cycles. The dependent instruction captured on the 3rd edge.
- x0 / no-match: lw x0 with RADDR1=0, then lw x7 with RADDR1=6, RADDR2=8 → STALL_STAGE2 never asserts.
- FLUSH in WAIT: hazard, then FLUSH=1 on the second stall cycle → STALL_STAGE2=0 that cycle, stage 3 bubble, state RUN next cycle.
- HOLD_IN: HOLD_IN=1 for 3 cycles with valid ALUOUT 0xDEAD_BEEF in stage 3 → outputs unchanged for 3 cycles and STALL_STAGE2=1 throughout. Resumes capture on the first edge after release.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared stage-3 pipeline types: opcode constants, stage-3 register layout and FSM states.
package pipe_pkg;

    localparam int unsigned PIPE_XLEN = 32;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALUI  = 7'b0010011;
    localparam logic [6:0] OP_ALUR  = 7'b0110011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic [PIPE_XLEN-1:0] alu;
        logic [PIPE_XLEN-1:0] store;
        logic [6:0]           opcode;
        logic [4:0]           wr_addr;
        logic                 wr_en;
        logic                 valid;
    } stage3_t;

    localparam stage3_t BUBBLE_S3 = '0;

    typedef enum logic [0:0] {
        ST_RUN,
        ST_WAIT
    } s3_state_t;

endpackage

// File: rtl/stage3_pipe_load_use_detect.sv
// Combinational load-use compare: a valid, register-writing load whose destination
// is read by the instruction behind it.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic       valid,
    input  logic [6:0] opcode,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [4:0] raddr1,
    input  logic [4:0] raddr2,
    output logic       hazard
);

    assign hazard = valid && (opcode == OP_LOAD) && wr_en &&
                    ((wr_addr == raddr1) || (wr_addr == raddr2));

endmodule

// File: rtl/stage3_pipe.sv
// EX/MEM pipeline register with load-use stall controller: bubbles stage 3 and holds
// stage 2 for LOAD_LAT cycles when stage 2 reads a load destination sitting in stage 3.
module stage3_pipe
    import pipe_pkg::*;
#(
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] ALUOUT_STAGE2,
    input  logic [XLEN-1:0] RS2_FWD_STAGE2,
    input  logic [6:0]      OPCODE_STAGE2,
    input  logic [4:0]      wr_addr_STAGE2,
    input  logic            WR_EN_STAGE2,
    input  logic [4:0]      RADDR1_STAGE2,
    input  logic [4:0]      RADDR2_STAGE2,
    input  logic            FLUSH,
    input  logic            HOLD_IN,
    output logic [XLEN-1:0] ALUOUT_STAGE3,
    output logic [XLEN-1:0] STORE_DATA_STAGE3,
    output logic [6:0]      OPCODE_STAGE3,
    output logic [4:0]      wr_addr_STAGE3,
    output logic            WR_EN_STAGE3,
    output logic            VALID_STAGE3,
    output logic            STALL_STAGE2
);

    localparam int unsigned CW = $clog2(LOAD_LAT + 1);

    stage3_t        s3_q, s3_d;
    s3_state_t      state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           hazard;

    load_use_detect u_load_use_detect (
        .valid   (s3_q.valid),
        .opcode  (s3_q.opcode),
        .wr_en   (s3_q.wr_en),
        .wr_addr (s3_q.wr_addr),
        .raddr1  (RADDR1_STAGE2),
        .raddr2  (RADDR2_STAGE2),
        .hazard  (hazard)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_q    <= BUBBLE_S3;
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            s3_q    <= s3_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FLUSH outranks everything, then HOLD_IN; the hazard cycle itself is the first bubble,
    // so WAIT only covers the remaining LOAD_LAT-1 bubbles.
    always_comb begin
        s3_d         = s3_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        STALL_STAGE2 = 1'b0;
        if (FLUSH) begin
            s3_d    = BUBBLE_S3;
            state_d = ST_RUN;
            cnt_d   = '0;
        end else if (HOLD_IN) begin
            STALL_STAGE2 = 1'b1;
        end else if (state_q == ST_WAIT) begin
            STALL_STAGE2 = 1'b1;
            s3_d         = BUBBLE_S3;
            cnt_d        = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = ST_RUN;
            end
        end else if (hazard) begin
            STALL_STAGE2 = 1'b1;
            s3_d         = BUBBLE_S3;
            if (LOAD_LAT > 1) begin
                cnt_d   = CW'(LOAD_LAT - 1);
                state_d = ST_WAIT;
            end
        end else begin
            s3_d.alu     = ALUOUT_STAGE2;
            s3_d.store   = RS2_FWD_STAGE2;
            s3_d.opcode  = OPCODE_STAGE2;
            s3_d.wr_addr = wr_addr_STAGE2;
            s3_d.wr_en   = WR_EN_STAGE2 && (wr_addr_STAGE2 != 5'd0);
            s3_d.valid   = 1'b1;
        end
    end

    assign ALUOUT_STAGE3     = s3_q.alu;
    assign STORE_DATA_STAGE3 = s3_q.store;
    assign OPCODE_STAGE3     = s3_q.opcode;
    assign wr_addr_STAGE3    = s3_q.wr_addr;
    assign WR_EN_STAGE3      = s3_q.wr_en;
    assign VALID_STAGE3      = s3_q.valid;

endmodule

// File: tb/tb_stage3_pipe.sv
// Directed bench for stage3_pipe: a bubble-count model checked every negedge, plus
// hand-computed literal expectations at key points of each scenario.
module tb_stage3_pipe;

    localparam int unsigned LOAD_LAT = 2;
    localparam int unsigned XLEN     = 32;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] ADI = 7'b0010011;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [XLEN-1:0] alu2, rs2_2;
    logic [6:0]      op2;
    logic [4:0]      wa2, r1, r2;
    logic            we2, flush, hold;
    logic [XLEN-1:0] alu3, st3;
    logic [6:0]      op3;
    logic [4:0]      wa3;
    logic            we3, v3, stall;

    int n_vec = 0;
    int n_bad = 0;

    stage3_pipe #(.LOAD_LAT(LOAD_LAT), .XLEN(XLEN)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ALUOUT_STAGE2     (alu2),
        .RS2_FWD_STAGE2    (rs2_2),
        .OPCODE_STAGE2     (op2),
        .wr_addr_STAGE2    (wa2),
        .WR_EN_STAGE2      (we2),
        .RADDR1_STAGE2     (r1),
        .RADDR2_STAGE2     (r2),
        .FLUSH             (flush),
        .HOLD_IN           (hold),
        .ALUOUT_STAGE3     (alu3),
        .STORE_DATA_STAGE3 (st3),
        .OPCODE_STAGE3     (op3),
        .wr_addr_STAGE3    (wa3),
        .WR_EN_STAGE3      (we3),
        .VALID_STAGE3      (v3),
        .STALL_STAGE2      (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: expected stage-3 contents plus the number of bubbles still owed to a load-use stall.
    logic [31:0] m_alu, m_st;
    logic [6:0]  m_op;
    logic [4:0]  m_wa;
    logic        m_we, m_v;
    int          pending;

    function automatic logic m_hazard();
        return m_v && (m_op == LD) && m_we && (m_wa == r1 || m_wa == r2);
    endfunction

    function automatic logic m_stall();
        return !flush && (hold || pending > 0 || m_hazard());
    endfunction

    task automatic m_bubble();
        m_alu = '0; m_st = '0; m_op = '0; m_wa = '0; m_we = 1'b0; m_v = 1'b0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_bubble();
            pending = 0;
        end else if (flush) begin
            m_bubble();
            pending = 0;
        end else if (hold) begin
            // frozen
        end else if (pending > 0 || m_hazard()) begin
            if (pending == 0) pending = LOAD_LAT;
            pending--;
            m_bubble();
        end else begin
            m_alu = alu2; m_st = rs2_2; m_op = op2; m_wa = wa2;
            m_we  = we2 && (wa2 != 5'd0);
            m_v   = 1'b1;
        end
    end

    always @(negedge clk) begin
        check("alu3",  alu3, m_alu);
        check("st3",   st3,  m_st);
        check("op3",   32'(op3), 32'(m_op));
        check("wa3",   32'(wa3), 32'(m_wa));
        check("we3",   32'(we3), 32'(m_we));
        check("v3",    32'(v3),  32'(m_v));
        check("stall", 32'(stall), 32'(m_stall()));
    end

    task automatic set_in(input logic [6:0] op, input logic [31:0] a, input logic [31:0] s,
                          input logic [4:0] wa, input logic we, input logic [4:0] ra, input logic [4:0] rb);
        op2 = op; alu2 = a; rs2_2 = s; wa2 = wa; we2 = we; r1 = ra; r2 = rb;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; hold = 1'b0;
        set_in(7'd0, '0, '0, 5'd0, 1'b0, 5'd0, 5'd0);
        tick(); tick();
        check("rst_valid", 32'(v3), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        rst_n = 1'b1;

        // ALU passthrough
        set_in(ADI, 32'h10, 32'h0, 5'd5, 1'b1, 5'd1, 5'd2);
        tick();
        check("addi_alu", alu3, 32'h10);
        check("addi_wa", 32'(wa3), 32'd5);
        check("addi_valid", 32'(v3), 32'd1);
        check("addi_stall", 32'(stall), 32'd0);

        // store data path
        set_in(ST, 32'h80, 32'hCAFE, 5'd0, 1'b0, 5'd3, 5'd4);
        tick();
        check("store_data", st3, 32'hCAFE);

        // load-use via rs1: two bubbles, dependent captured on third edge
        set_in(LD, 32'h100, 32'h0, 5'd7, 1'b1, 5'd0, 5'd0);
        tick();
        set_in(ADI, 32'h22, 32'h0, 5'd9, 1'b1, 5'd7, 5'd3);
        #1 check("lu_stall0", 32'(stall), 32'd1);
        tick();
        check("lu_v1", 32'(v3), 32'd0);
        check("lu_stall1", 32'(stall), 32'd1);
        tick();
        check("lu_v2", 32'(v3), 32'd0);
        check("lu_stall2", 32'(stall), 32'd0);
        tick();
        check("lu_dep_valid", 32'(v3), 32'd1);
        check("lu_dep_alu", alu3, 32'h22);

        // x0 load and non-matching reads never stall
        set_in(LD, 32'h104, 32'h0, 5'd0, 1'b1, 5'd0, 5'd0);
        tick();
        check("x0_we", 32'(we3), 32'd0);
        set_in(LD, 32'h108, 32'h0, 5'd7, 1'b1, 5'd0, 5'd0);
        #1 check("x0_stall", 32'(stall), 32'd0);
        tick();
        set_in(ADI, 32'h1, 32'h0, 5'd10, 1'b1, 5'd6, 5'd8);
        #1 check("nomatch_stall", 32'(stall), 32'd0);
        tick();

        // FLUSH during WAIT
        set_in(LD, 32'h200, 32'h0, 5'd7, 1'b1, 5'd0, 5'd0);
        tick();
        set_in(ADI, 32'h33, 32'h0, 5'd11, 1'b1, 5'd7, 5'd0);
        tick();
        flush = 1'b1;
        #1 check("flush_stall", 32'(stall), 32'd0);
        tick();
        check("flush_bubble", 32'(v3), 32'd0);
        flush = 1'b0;
        set_in(ADI, 32'h44, 32'h0, 5'd4, 1'b1, 5'd1, 5'd1);
        #1 check("flush_run", 32'(stall), 32'd0);
        tick();
        check("flush_next", alu3, 32'h44);

        // HOLD_IN freezes stage 3
        set_in(ADI, 32'hDEAD_BEEF, 32'h0, 5'd3, 1'b1, 5'd0, 5'd0);
        tick();
        set_in(ADI, 32'h55, 32'h0, 5'd6, 1'b1, 5'd0, 5'd0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("hold_stall", 32'(stall), 32'd1);
            tick();
            check("hold_alu", alu3, 32'hDEAD_BEEF);
        end
        hold = 1'b0;
        #1 check("hold_rel_stall", 32'(stall), 32'd0);
        tick();
        check("hold_resume", alu3, 32'h55);

        // back-to-back dependent loads, rs2 match, HOLD_IN inside WAIT
        set_in(LD, 32'h300, 32'h0, 5'd8, 1'b1, 5'd0, 5'd0);
        tick();
        set_in(LD, 32'h304, 32'h0, 5'd9, 1'b1, 5'd8, 5'd0);
        tick(); tick(); tick();
        check("b2b_wa", 32'(wa3), 32'd9);
        set_in(ADI, 32'h66, 32'h0, 5'd12, 1'b1, 5'd0, 5'd9);
        #1 check("b2b_stall", 32'(stall), 32'd1);
        tick();
        hold = 1'b1;
        tick(); tick();
        check("wait_hold_v", 32'(v3), 32'd0);
        hold = 1'b0;
        #1 check("wait_after_hold", 32'(stall), 32'd1);
        tick();
        #1 check("wait_done", 32'(stall), 32'd0);
        tick();
        check("b2b_dep", 32'(wa3), 32'd12);

        // asynchronous reset mid-cycle with stage 3 full
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(v3), 32'd0);
        check("arst_alu", alu3, 32'h0);
        check("arst_wa", 32'(wa3), 32'd0);
        tick();
        rst_n = 1'b1;
        set_in(ADI, 32'h77, 32'h0, 5'd13, 1'b1, 5'd0, 5'd0);
        tick();
        check("post_rst_alu", alu3, 32'h77);
        check("post_rst_valid", 32'(v3), 32'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
